// File: rtl/multicycle_adder_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_adder_ctrl : WIDTH-bit add/sub, one byte slice per cycle through
//                         a single shared 8-bit carry-select adder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module carry_select_adder_8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_c_in,
  output logic [7:0] o_sum,
  output logic       o_c_out
);
  logic [4:0] w_lo;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;

  // Upper nibble is precomputed for both carry-ins and selected by the low carry.
  assign w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_c_in};
  assign w_hi0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
  assign w_hi1 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'd1;

  assign {o_c_out, o_sum[7:4]} = w_lo[4] ? w_hi1 : w_hi0;
  assign o_sum[3:0]            = w_lo[3:0];
endmodule

module multicycle_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             Overflow
);
  localparam int c_NSLICE = WIDTH / 8;
  localparam int c_CW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;

  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
      $error("multicycle_adder_ctrl: WIDTH must be a multiple of 8 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_CW-1:0]   r_cnt;
  logic              r_carry;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [WIDTH-1:0]  r_s;
  logic              r_c_out;
  logic              r_ovf;
  logic [7:0]        w_a_slice;
  logic [7:0]        w_b_slice;
  logic [7:0]        w_sum;
  logic              w_c;
  logic              w_last;

  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < c_NSLICE; i++) begin
      if (r_cnt == c_CW'(i)) begin
        w_a_slice = r_op_a[8*i +: 8];
        w_b_slice = r_op_b[8*i +: 8];
      end
    end
  end

  assign w_last = (r_cnt == c_CW'(c_NSLICE - 1));

  carry_select_adder_8 u_adder (
    .i_a     (w_a_slice),
    .i_b     (w_b_slice),
    .i_c_in  (r_carry),
    .o_sum   (w_sum),
    .o_c_out (w_c)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (Run)    w_next = ST_ADD;
      ST_ADD:  if (w_last) w_next = ST_DONE;
      ST_DONE:             w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Run) begin
            // Subtraction is A + ~B + 1: invert B here, the +1 rides in on the carry.
            r_op_a  <= A;
            r_op_b  <= B ^ {WIDTH{Sub}};
            r_carry <= Sub;
            r_cnt   <= '0;
          end
        end
        ST_ADD: begin
          for (int i = 0; i < c_NSLICE; i++) begin
            if (r_cnt == c_CW'(i)) r_s[8*i +: 8] <= w_sum;
          end
          r_carry <= w_c;
          r_cnt   <= r_cnt + c_CW'(1);
          if (w_last) begin
            r_c_out <= w_c;
            r_ovf   <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &
                       (w_sum[7] != r_op_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy     = (r_state != ST_IDLE);
  assign Done     = (r_state == ST_DONE);
  assign S        = r_s;
  assign C_out    = r_c_out;
  assign Overflow = r_ovf;
endmodule

`default_nettype wire
